// File: rtl/dsp_nco_sweep_ctrl.sv
// Stepped-frequency sweep sequencer feeding dsp_nco en/phi_inc.
// Walks phi_inc through N+1 tones, each held for a programmable dwell.
module dsp_nco_sweep_ctrl #(
  parameter int PHI_WIDTH   = 32,
  parameter int DWELL_WIDTH = 16,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic [PHI_WIDTH-1:0]   cfg_phi_start,
  input  logic [PHI_WIDTH-1:0]   cfg_phi_step,
  input  logic [CNT_WIDTH-1:0]   cfg_num_steps,
  input  logic [DWELL_WIDTH-1:0] cfg_dwell,
  input  logic                   cfg_loop,
  output logic                   nco_en,
  output logic [PHI_WIDTH-1:0]   nco_phi_inc,
  output logic                   busy,
  output logic                   done,
  output logic [CNT_WIDTH-1:0]   step_idx,
  output logic                   step_stb
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam logic [DWELL_WIDTH-1:0] D_ONE = 1;
  localparam logic [CNT_WIDTH-1:0]   C_ONE = 1;

  state_t state, state_n;

  logic [PHI_WIDTH-1:0]   sh_start, sh_start_n;
  logic [PHI_WIDTH-1:0]   sh_step, sh_step_n;
  logic [CNT_WIDTH-1:0]   sh_num, sh_num_n;
  logic [DWELL_WIDTH-1:0] sh_dwell, sh_dwell_n;
  logic                   sh_loop, sh_loop_n;
  logic [DWELL_WIDTH-1:0] cnt, cnt_n;

  logic                   en_n;
  logic [PHI_WIDTH-1:0]   phi_n;
  logic                   busy_n;
  logic                   done_n;
  logic [CNT_WIDTH-1:0]   idx_n;
  logic                   stb_n;

  logic last_cyc;
  logic last_tone;

  // A dwell of 0 behaves like 1: every cycle ends the tone.
  assign last_cyc  = (sh_dwell <= D_ONE) ||
                     (cnt == sh_dwell - D_ONE);
  assign last_tone = (step_idx == sh_num);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      sh_start    <= '0;
      sh_step     <= '0;
      sh_num      <= '0;
      sh_dwell    <= '0;
      sh_loop     <= 1'b0;
      cnt         <= '0;
      nco_en      <= 1'b0;
      nco_phi_inc <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      step_idx    <= '0;
      step_stb    <= 1'b0;
    end else begin
      state       <= state_n;
      sh_start    <= sh_start_n;
      sh_step     <= sh_step_n;
      sh_num      <= sh_num_n;
      sh_dwell    <= sh_dwell_n;
      sh_loop     <= sh_loop_n;
      cnt         <= cnt_n;
      nco_en      <= en_n;
      nco_phi_inc <= phi_n;
      busy        <= busy_n;
      done        <= done_n;
      step_idx    <= idx_n;
      step_stb    <= stb_n;
    end
  end

  always_comb begin
    state_n    = state;
    sh_start_n = sh_start;
    sh_step_n  = sh_step;
    sh_num_n   = sh_num;
    sh_dwell_n = sh_dwell;
    sh_loop_n  = sh_loop;
    cnt_n      = cnt;
    en_n       = nco_en;
    phi_n      = nco_phi_inc;
    busy_n     = busy;
    done_n     = 1'b0;
    idx_n      = step_idx;
    stb_n      = 1'b0;

    unique case (state)
      IDLE: begin
        if (start && !abort) begin
          sh_start_n = cfg_phi_start;
          sh_step_n  = cfg_phi_step;
          sh_num_n   = cfg_num_steps;
          sh_dwell_n = cfg_dwell;
          sh_loop_n  = cfg_loop;
          state_n    = RUN;
          cnt_n      = '0;
          en_n       = 1'b1;
          busy_n     = 1'b1;
          phi_n      = cfg_phi_start;
          idx_n      = '0;
          stb_n      = 1'b1;
        end
      end
      RUN: begin
        if (abort) begin
          state_n = IDLE;
          cnt_n   = '0;
          en_n    = 1'b0;
          busy_n  = 1'b0;
          phi_n   = '0;
          idx_n   = '0;
        end else if (!last_cyc) begin
          cnt_n = cnt + D_ONE;
        end else begin
          cnt_n = '0;
          if (!last_tone) begin
            phi_n = nco_phi_inc + sh_step;
            idx_n = step_idx + C_ONE;
            stb_n = 1'b1;
          end else if (sh_loop) begin
            phi_n = sh_start;
            idx_n = '0;
            stb_n = 1'b1;
          end else begin
            state_n = DONE;
            done_n  = 1'b1;
            en_n    = 1'b0;
            busy_n  = 1'b0;
            phi_n   = '0;
            idx_n   = '0;
          end
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_dsp_nco_sweep_ctrl.sv
// Directed + randomized bench for dsp_nco_sweep_ctrl.
// Expected tone trains are built arithmetically from the sweep rules.
module tb_dsp_nco_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] cfg_phi_start = '0;
  logic [31:0] cfg_phi_step = '0;
  logic [15:0] cfg_num_steps = '0;
  logic [15:0] cfg_dwell = '0;
  logic        cfg_loop = 1'b0;
  logic        nco_en;
  logic [31:0] nco_phi_inc;
  logic        busy;
  logic        done;
  logic [15:0] step_idx;
  logic        step_stb;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic        en;
    logic [31:0] phi;
    logic [15:0] idx;
    logic        stb;
    logic        busy;
    logic        done;
  } exp_t;

  localparam exp_t IDLE_E = '0;

  dsp_nco_sweep_ctrl dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .abort(abort),
    .cfg_phi_start(cfg_phi_start),
    .cfg_phi_step(cfg_phi_step),
    .cfg_num_steps(cfg_num_steps),
    .cfg_dwell(cfg_dwell),
    .cfg_loop(cfg_loop),
    .nco_en(nco_en),
    .nco_phi_inc(nco_phi_inc),
    .busy(busy),
    .done(done),
    .step_idx(step_idx),
    .step_stb(step_stb)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp_v);
    end
  endtask

  task automatic cmp(input string tag, input exp_t e);
    chk({tag, ".en"},   32'(nco_en),      32'(e.en));
    chk({tag, ".phi"},  nco_phi_inc,      e.phi);
    chk({tag, ".idx"},  32'(step_idx),    32'(e.idx));
    chk({tag, ".stb"},  32'(step_stb),    32'(e.stb));
    chk({tag, ".busy"}, 32'(busy),        32'(e.busy));
    chk({tag, ".done"}, 32'(done),        32'(e.done));
  endtask

  // Reference: tone k is start + k*step, held max(D,1) cycles.
  task automatic build(input logic [31:0] s,
                       input logic [31:0] st,
                       input int n, input int d,
                       input bit lp, input int max_cyc,
                       output exp_t q[$]);
    int dw;
    exp_t e;
    dw = (d == 0) ? 1 : d;
    q = {};
    do begin
      for (int k = 0; k <= n; k++) begin
        for (int c = 0; c < dw; c++) begin
          if (q.size() < max_cyc) begin
            e = '0;
            e.en   = 1'b1;
            e.phi  = s + st * 32'(k);
            e.idx  = 16'(k);
            e.stb  = (c == 0);
            e.busy = 1'b1;
            q.push_back(e);
          end
        end
      end
    end while (lp && q.size() < max_cyc);
    if (!lp) begin
      e = '0;
      e.done = 1'b1;
      q.push_back(e);
    end
  endtask

  task automatic sweep(input string tag,
                       input logic [31:0] s,
                       input logic [31:0] st,
                       input int n, input int d,
                       input bit lp, input int loop_cyc,
                       input bit disturb,
                       input bit start_in_done);
    exp_t q[$];
    build(s, st, n, d, lp, lp ? loop_cyc : 100000, q);
    @(negedge clk);
    cfg_phi_start = s;
    cfg_phi_step  = st;
    cfg_num_steps = 16'(n);
    cfg_dwell     = 16'(d);
    cfg_loop      = lp;
    start = 1'b1;
    @(negedge clk);
    for (int i = 0; i < q.size(); i++) begin
      cmp($sformatf("%s[%0d]", tag, i), q[i]);
      start = 1'b0;
      if (disturb && i == 0) begin
        cfg_phi_start = $urandom;
        cfg_phi_step  = $urandom;
        cfg_num_steps = 16'($urandom_range(0, 7));
        cfg_dwell     = 16'($urandom_range(0, 7));
        cfg_loop      = 1'b1;
        start = 1'b1;
      end
      if (start_in_done && q[i].done) start = 1'b1;
      if (lp && i == q.size() - 1) abort = 1'b1;
      @(negedge clk);
    end
    start = 1'b0;
    abort = 1'b0;
    cfg_loop = 1'b0;
    cmp({tag, ".after"}, IDLE_E);
  endtask

  initial begin
    #2;
    cmp("reset", IDLE_E);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    cmp("idle", IDLE_E);

    sweep("t1", 32'h0800_0000, 32'h0100_0000, 3, 4,
          1'b0, 0, 1'b0, 1'b1);
    sweep("t2", 32'h0080_0000, 32'hFF00_0000, 1, 2,
          1'b0, 0, 1'b0, 1'b0);
    sweep("t3", 32'h1234_0000, 32'h0000_1000, 1, 1,
          1'b1, 9, 1'b0, 1'b0);
    sweep("t4", 32'hDEAD_BEEF, 32'h1, 0, 0,
          1'b0, 0, 1'b0, 1'b0);
    sweep("t5", 32'h4000_0000, 32'hF000_0000, 2, 3,
          1'b0, 0, 1'b1, 1'b0);
    sweep("t5b", 32'h0000_0100, 32'h0000_0010, 1, 1,
          1'b0, 0, 1'b0, 1'b0);

    // abort beats start in IDLE
    @(negedge clk);
    cfg_phi_start = 32'h5555_0000;
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    cmp("abort_start", IDLE_E);
    @(negedge clk);
    cmp("abort_start2", IDLE_E);

    // async reset between edges mid-tone
    cfg_phi_start = 32'h0A00_0000;
    cfg_phi_step  = 32'h0000_0001;
    cfg_num_steps = 16'd4;
    cfg_dwell     = 16'd5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst.en", 32'(nco_en), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    cmp("async_rst", IDLE_E);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    cmp("post_rst", IDLE_E);
    sweep("t6", 32'h0C00_0000, 32'h0000_0100, 2, 2,
          1'b0, 0, 1'b0, 1'b0);

    for (int r = 0; r < 8; r++) begin
      sweep($sformatf("rnd%0d", r), $urandom, $urandom,
            int'($urandom_range(0, 5)),
            int'($urandom_range(0, 5)),
            r[0], int'($urandom_range(1, 20)),
            r[1], r[2]);
    end

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
